// File: rtl/proc_control_if.sv
// proc_control_if: instruction/control bundle between the sequencer and its datapath
interface proc_control_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
);
    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic [8:0]        ir;
    logic              IRin;
    logic [NREG-1:0]   Rin;
    logic [3:0]        bus_sel;
    logic              Ain;
    logic              Gin;
    logic              AddSub;
    logic              Done;
    logic [1:0]        state;

    modport master (
        output Run, DIN,
        input  ir, IRin, Rin, bus_sel, Ain, Gin, AddSub, Done, state
    );

    modport slave (
        input  Run, DIN,
        output ir, IRin, Rin, bus_sel, Ain, Gin, AddSub, Done, state
    );
endinterface

// File: rtl/proc_control.sv
// proc_control: instruction-sequencing FSM for mv/mvi/add/sub
module proc_control #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input logic           CLOCK_50,
    input logic           reset,
    proc_control_if.slave bus
);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    state_t          cur, nxt;
    logic [8:0]      ir_q;
    logic [2:0]      op, x, y;
    logic [NREG-1:0] x_hot;
    logic            unused_din;

    assign op          = ir_q[8:6];
    assign x           = ir_q[5:3];
    assign y           = ir_q[2:0];
    assign x_hot       = {{(NREG-1){1'b0}}, 1'b1} << x;
    assign bus.ir      = ir_q;
    assign bus.state   = cur;
    assign unused_din  = ^bus.DIN[DATA_W-1:9];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cur  <= T0;
            ir_q <= '0;
        end else begin
            cur <= nxt;
            if (cur == T0 && bus.Run)
                ir_q <= bus.DIN[8:0];
        end
    end

    always_comb begin
        nxt = cur == T0 ? (bus.Run ? T1 : T0) :
              cur == T1 ? (op[2:1] == 2'b01 ? T2 : T0) :
              cur == T2 ? T3 : T0;
    end

    // Controls are held inactive for as long as reset is asserted
    always_comb begin
        bus.IRin    = 1'b0;
        bus.Rin     = '0;
        bus.bus_sel = 4'd15;
        bus.Ain     = 1'b0;
        bus.Gin     = 1'b0;
        bus.AddSub  = 1'b0;
        bus.Done    = 1'b0;
        if (!reset) begin
            case (cur)
                T0: bus.IRin = bus.Run;
                T1: begin
                    if (op[2]) begin
                        bus.Done = 1'b1;
                    end else if (op[1]) begin
                        bus.bus_sel = {1'b0, x};
                        bus.Ain     = 1'b1;
                    end else begin
                        bus.bus_sel = op[0] ? 4'd8 : {1'b0, y};
                        bus.Rin     = x_hot;
                        bus.Done    = 1'b1;
                    end
                end
                T2: begin
                    bus.bus_sel = {1'b0, y};
                    bus.Gin     = 1'b1;
                    bus.AddSub  = op[0];
                end
                T3: begin
                    bus.bus_sel = 4'd9;
                    bus.Rin     = x_hot;
                    bus.Done    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: directed vector table plus randomized run against a per-instruction step-list model
module tb_proc_control;
    typedef struct packed {
        logic [1:0] st;
        logic [8:0] ir;
        logic       irin;
        logic [7:0] rin;
        logic [3:0] bsel;
        logic       ain;
        logic       gin;
        logic       as;
        logic       done;
    } obs_t;

    typedef struct {
        logic        rs;
        logic        run;
        logic [15:0] din;
        obs_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    obs_t q[$];
    logic [8:0] ir_m;
    vec_t tbl[29];

    always #5 clk = ~clk;

    proc_control_if #(.DATA_W(16), .NREG(8)) bus();
    proc_control #(.DATA_W(16), .NREG(8)) dut (.CLOCK_50(clk), .reset(reset), .bus(bus));

    function automatic obs_t mk(logic [1:0] st, logic [8:0] ir, logic irin, logic [7:0] rin,
                                logic [3:0] bsel, logic ain, logic gin, logic as, logic done);
        return {st, ir, irin, rin, bsel, ain, gin, as, done};
    endfunction

    function automatic vec_t v(logic rs, logic run, logic [15:0] din, obs_t e);
        vec_t t;
        t.rs = rs;
        t.run = run;
        t.din = din;
        t.exp = e;
        return t;
    endfunction

    function automatic obs_t actual();
        return {bus.state, bus.ir, bus.IRin, bus.Rin, bus.bus_sel, bus.Ain, bus.Gin, bus.AddSub, bus.Done};
    endfunction

    task automatic check(string name, int idx, obs_t act, obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got st=%0d ir=%h irin=%b rin=%h bsel=%0d ain=%b gin=%b as=%b done=%b, want st=%0d ir=%h irin=%b rin=%h bsel=%0d ain=%b gin=%b as=%b done=%b",
                     name, idx, act.st, act.ir, act.irin, act.rin, act.bsel, act.ain, act.gin, act.as, act.done,
                     exp.st, exp.ir, exp.irin, exp.rin, exp.bsel, exp.ain, exp.gin, exp.as, exp.done);
        end
    endtask

    task automatic drive(logic rs, logic run, logic [15:0] din);
        reset = rs;
        bus.Run = run;
        bus.DIN = din;
    endtask

    // Each fetched instruction expands into the list of cycles it will occupy after T0
    task automatic push_instr(logic [8:0] i);
        logic [2:0] opc, x, y;
        logic [7:0] hot;
        opc = i[8:6];
        x = i[5:3];
        y = i[2:0];
        hot = 8'h01 << x;
        if (opc[2])
            q.push_back(mk(2'd1, i, 1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1));
        else if (opc == 3'd0)
            q.push_back(mk(2'd1, i, 1'b0, hot, {1'b0, y}, 1'b0, 1'b0, 1'b0, 1'b1));
        else if (opc == 3'd1)
            q.push_back(mk(2'd1, i, 1'b0, hot, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1));
        else begin
            q.push_back(mk(2'd1, i, 1'b0, 8'h00, {1'b0, x}, 1'b1, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(2'd2, i, 1'b0, 8'h00, {1'b0, y}, 1'b0, 1'b1, opc[0], 1'b0));
            q.push_back(mk(2'd3, i, 1'b0, hot, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    function automatic obs_t model_expect(logic rs, logic run);
        obs_t e;
        e = q.size() > 0 ? q[0] : mk(2'd0, ir_m, run, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        if (rs)
            e = mk(e.st, e.ir, 1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        return e;
    endfunction

    task automatic model_step(logic rs, logic run, logic [15:0] din);
        if (rs) begin
            q.delete();
            ir_m = 9'h000;
        end else if (q.size() > 0) begin
            q.delete(0);
        end else if (run) begin
            ir_m = din[8:0];
            push_instr(ir_m);
        end
    endtask

    initial begin
        obs_t idle0;
        logic rs, run;
        logic [15:0] din;
        idle0 = mk(2'd0, 9'h000, 1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[0]  = v(1'b1, 1'b1, 16'h0040, idle0);
        tbl[1]  = v(1'b1, 1'b1, 16'h0040, idle0);
        tbl[2]  = v(1'b0, 1'b0, 16'h0000, idle0);
        tbl[3]  = v(1'b0, 1'b1, 16'h0040, mk(2'd0, 9'h000, 1'b1, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[4]  = v(1'b0, 1'b0, 16'h0005, mk(2'd1, 9'h040, 1'b0, 8'h01, 4'd8,  1'b0, 1'b0, 1'b0, 1'b1));
        tbl[5]  = v(1'b0, 1'b1, 16'h0008, mk(2'd0, 9'h040, 1'b1, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[6]  = v(1'b0, 1'b0, 16'h0000, mk(2'd1, 9'h008, 1'b0, 8'h02, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1));
        tbl[7]  = v(1'b0, 1'b1, 16'h0081, mk(2'd0, 9'h008, 1'b1, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[8]  = v(1'b0, 1'b1, 16'h00C1, mk(2'd1, 9'h081, 1'b0, 8'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl[9]  = v(1'b0, 1'b1, 16'h00C1, mk(2'd2, 9'h081, 1'b0, 8'h00, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0));
        tbl[10] = v(1'b0, 1'b1, 16'h00C1, mk(2'd3, 9'h081, 1'b0, 8'h01, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1));
        tbl[11] = v(1'b0, 1'b1, 16'h00C1, mk(2'd0, 9'h081, 1'b1, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[12] = v(1'b0, 1'b1, 16'h00C1, mk(2'd1, 9'h0C1, 1'b0, 8'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl[13] = v(1'b0, 1'b0, 16'h0000, mk(2'd2, 9'h0C1, 1'b0, 8'h00, 4'd1,  1'b0, 1'b1, 1'b1, 1'b0));
        tbl[14] = v(1'b0, 1'b0, 16'h0000, mk(2'd3, 9'h0C1, 1'b0, 8'h01, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1));
        tbl[15] = v(1'b0, 1'b1, 16'h0081, mk(2'd0, 9'h0C1, 1'b1, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[16] = v(1'b0, 1'b0, 16'h0000, mk(2'd1, 9'h081, 1'b0, 8'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl[17] = v(1'b1, 1'b0, 16'h0000, mk(2'd2, 9'h081, 1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[18] = v(1'b0, 1'b0, 16'h0000, idle0);
        tbl[19] = v(1'b0, 1'b1, 16'h0100, mk(2'd0, 9'h000, 1'b1, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[20] = v(1'b0, 1'b0, 16'h0000, mk(2'd1, 9'h100, 1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1));
        tbl[21] = v(1'b0, 1'b0, 16'h0000, mk(2'd0, 9'h100, 1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[22] = v(1'b0, 1'b1, 16'h009B, mk(2'd0, 9'h100, 1'b1, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[23] = v(1'b0, 1'b0, 16'h0000, mk(2'd1, 9'h09B, 1'b0, 8'h00, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl[24] = v(1'b0, 1'b0, 16'h0000, mk(2'd2, 9'h09B, 1'b0, 8'h00, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0));
        tbl[25] = v(1'b0, 1'b0, 16'h0000, mk(2'd3, 9'h09B, 1'b0, 8'h08, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1));
        tbl[26] = v(1'b0, 1'b1, 16'h003F, mk(2'd0, 9'h09B, 1'b1, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[27] = v(1'b0, 1'b0, 16'h0000, mk(2'd1, 9'h03F, 1'b0, 8'h80, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1));
        tbl[28] = v(1'b0, 1'b0, 16'h0000, mk(2'd0, 9'h03F, 1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0));

        drive(1'b1, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].rs, tbl[i].run, tbl[i].din);
            @(negedge clk);
            check("table", i, actual(), tbl[i].exp);
            @(posedge clk);
            #1;
        end

        drive(1'b1, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        q.delete();
        ir_m = 9'h000;
        for (int i = 0; i < 500; i++) begin
            rs = $urandom_range(31) == 0;
            run = 1'($urandom_range(1));
            din = 16'($urandom);
            drive(rs, run, din);
            @(negedge clk);
            check("random", i, actual(), model_expect(rs, run));
            model_step(rs, run, din);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/proc_control.md
Name: proc_control

Overview:
- Instruction-sequencing FSM for the simple processor.
- Captures a 9-bit instruction from DIN and drives the bus-select, register-load, A/G-load and addsub controls that steer the 16-bit alu (rx from register A, ry from the bus) and the R0-R7 register file.
- Supports mv, mvi, add and sub, each completing in 1 or 3 cycles after fetch, and signals completion with Done.

Parameters:
- DATA_W, 16, width of DIN and of the datapath bus.
- NREG, 8, number of general registers; fixes the width of Rin and the bus_sel range 0..NREG-1.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Run  in  1  start request, sampled only in state T0.
- DIN  in  DATA_W  instruction word in T0 (bits [8:6] opcode, [5:3] X, [2:0] Y); immediate data word in T1 of mvi.
- ir  out  9  current instruction register contents.
- IRin  out  1  instruction register load strobe (informational copy for the datapath).
- Rin  out  NREG  one-hot register-file write enable.
- bus_sel  out  4  bus source select: 0-7 = R0-R7, 8 = DIN, 9 = G, 15 = none.
- Ain  out  1  load register A (alu rx operand) from the bus.
- Gin  out  1  load register G from the alu result.
- AddSub  out  1  alu addsub: 0 = rx+ry, 1 = rx-ry.
- Done  out  1  high in the final cycle of an instruction.
- state  out  2  current FSM state: T0=0, T1=1, T2=2, T3=3.

Behaviour:
- State register: state, ir.
- While reset=1 at a rising edge: next state = T0 and ir = 0.
- Outputs are combinational from state, ir and Run.
- While reset=1 all outputs are forced inactive: IRin=0, Rin=0, bus_sel=15, Ain=Gin=AddSub=Done=0.
- Default in every state: Rin=0, bus_sel=15, Ain=Gin=AddSub=Done=0, IRin=0.
- T0:
  - IRin=Run.
  - If Run=1: ir <= DIN[8:0] and next state T1.
  - Otherwise stay in T0 and ir holds.
- T1, by opcode:
  - 000 mv: bus_sel=Y, Rin[X]=1, Done=1, next state T0.
  - 001 mvi: bus_sel=8, Rin[X]=1, Done=1, next state T0. DIN must carry the immediate in this cycle.
  - 010 add / 011 sub: bus_sel=X, Ain=1, next state T2.
  - 1xx undefined: Done=1, no other controls asserted, next state T0.
- T2 (add/sub only): bus_sel=Y, Gin=1, AddSub=opcode[0], next state T3.
- T3: bus_sel=9, Rin[X]=1, Done=1, next state T0.
- Run is ignored outside T0. An instruction cannot be aborted except by reset.
- Latency from the Run-sampling edge to the Done cycle: 1 cycle for mv/mvi/undefined, 3 cycles for add/sub.
- Back-to-back: after Done the FSM is in T0 on the next cycle; if Run=1 there, the next instruction is fetched with no bubble.
- X==Y is legal:
  - mv Rx,Rx rewrites the same value.
  - add Rx,Rx doubles Rx.
  - sub Rx,Rx yields 0.
- Arithmetic wrap-around is modulo 2^DATA_W inside the alu; the controller does not flag overflow.
- Reset mid-instruction (T1-T3): the next cycle is T0 with ir=0. Writes already strobed stay committed; pending steps are discarded.
- Rin is always one-hot or zero. bus_sel never takes a value in 10-14.

Test Plan:
- Hold reset=1 for 2 cycles with Run=1 -> state=0, ir=0, all strobes 0, bus_sel=15. Release with Run=0 -> state stays 0, IRin=0.
- mvi R0,#5: DIN=0x0040 with Run=1 at T0, then DIN=0x0005 -> T1 shows bus_sel=8, Rin=0x01, Done=1; the following cycle state=0.
- mv R1,R0: DIN=0x0008 with Run=1 -> T1 shows bus_sel=0, Rin=0x02, Done=1.
- add R0,R1: DIN=0x0081 with Run=1 -> expected cycles:
  - T1: bus_sel=0, Ain=1.
  - T2: bus_sel=1, Gin=1, AddSub=0.
  - T3: bus_sel=9, Rin=0x01, Done=1.
  - With Run held at 1 and DIN=0x00C1 in the next cycle, sub is fetched immediately.
- sub R0,R1: DIN=0x00C1 -> T2 shows AddSub=1, bus_sel=1, Gin=1; T3 shows Rin=0x01, Done=1.
- Start add (0x0081) and assert reset during T2 -> next cycle state=0, ir=0, Gin=0, no Rin pulse. Then issue undefined 0x0100 -> T1 shows Done=1 with Rin=0, Ain=Gin=0, bus_sel=15.
